// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - SRAM bus target: cs/we/oe decode, self-clear, pipelined reads, error flags, access counters
module sram_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              we_n,
  input  logic              oe_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic              err_flag,
  output logic [7:0]        rd_count,
  output logic [7:0]        wr_count
);

  localparam int DEPTH   = 2 ** ADDR_W;
  // RD_LAT=1 returns straight from the array, so the pipe needs RD_LAT-1 stages (at least one declared)
  localparam int PIPE_N  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam int OUT_IDX = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PIPE_N-1:0]   pipe_v;
  logic [DATA_W-1:0]   pipe_d [PIPE_N];

  logic                wr_acc;
  logic                rd_acc;
  logic                ill_acc;
  logic                busy_hit;
  logic [DATA_W-1:0]   rd_word;
  logic                ret_v;
  logic [DATA_W-1:0]   ret_d;

  always_comb begin
    wr_acc   = 1'b0;
    rd_acc   = 1'b0;
    ill_acc  = 1'b0;
    busy_hit = 1'b0;
    if (state == ST_IDLE) begin
      wr_acc  = !cs_n && !we_n &&  oe_n;
      rd_acc  = !cs_n &&  we_n && !oe_n;
      ill_acc = !cs_n && !we_n && !oe_n;
    end else begin
      busy_hit = !cs_n;
    end
  end

  assign rd_word = mem[addr];

  always_comb begin
    ret_v = 1'b0;
    ret_d = '0;
    if (RD_LAT == 1) begin
      ret_v = rd_acc;
      ret_d = rd_word;
    end else begin
      ret_v = pipe_v[OUT_IDX];
      ret_d = pipe_d[OUT_IDX];
    end
  end

  // Array kept reset-free so it maps onto RAM; the CLEAR walk zeroes it instead
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc) begin
      mem[addr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      busy     <= 1'b1;
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      err_flag <= 1'b0;
      rd_count <= 8'd0;
      wr_count <= 8'd0;
      pipe_v   <= '0;
      for (int i = 0; i < PIPE_N; i++) begin
        pipe_d[i] <= '0;
      end
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase

      pipe_v[0] <= rd_acc;
      pipe_d[0] <= rd_word;
      for (int i = 1; i < PIPE_N; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end

      rd_valid <= ret_v;
      if (ret_v) begin
        data_out <= ret_d;
      end

      err <= ill_acc || busy_hit;
      if (ill_acc || busy_hit) begin
        err_flag <= 1'b1;
      end

      if (rd_acc && (rd_count != 8'hFF)) begin
        rd_count <= rd_count + 8'd1;
      end
      if (wr_acc && (wr_count != 8'hFF)) begin
        wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - self-checking bench for sram_responder with a read-data scoreboard
module tb_sram_responder;

  logic       clk;
  logic       reset;
  logic       cs_n;
  logic       we_n;
  logic       oe_n;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       busy;
  logic       err;
  logic       err_flag;
  logic [7:0] rd_count;
  logic [7:0] wr_count;

  sram_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .we_n     (we_n),
    .oe_n     (oe_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .busy     (busy),
    .err      (err),
    .err_flag (err_flag),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] model [32];
  int         exp_rd;
  int         exp_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        check("rd_data", {24'd0, data_out}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    exp_rd = 0;
    exp_wr = 0;
    sb_q.delete();
  endtask

  task automatic drive_idle();
    cs_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    cs_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a; data_in = d;
    tick();
    model[a] = d;
    if (exp_wr < 255) exp_wr++;
  endtask

  task automatic do_read(input logic [4:0] a);
    cs_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = a;
    sb_q.push_back(model[a]);
    if (exp_rd < 255) exp_rd++;
    tick();
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    repeat (n) tick();
  endtask

  task automatic wait_idle(output int edges);
    edges = 0;
    while (busy && edges < 200) begin
      tick();
      edges++;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  int edges;

  initial begin
    reset = 1'b1;
    addr = '0;
    data_in = '0;
    drive_idle();
    model_reset();
    repeat (2) tick();

    // Reset state
    check("rst_busy", busy, 1);
    check("rst_data_out", data_out, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_wr_count", wr_count, 0);

    // Clear sequence length, then every word reads back as zero
    reset = 1'b0;
    wait_idle(edges);
    check("clear_edges", edges, 32);
    for (int i = 0; i < 32; i++) do_read(5'(i));
    idle_cycles(4);
    check("cleared_rd_count", rd_count, 32'(exp_rd));
    check("cleared_err_flag", err_flag, 0);

    // Write then immediate read, exact latency and hold
    do_write(5'd3, 8'hA5);
    do_read(5'd3);
    drive_idle();
    check("lat_not_early", rd_valid, 0);
    tick();
    check("lat_valid", rd_valid, 1);
    check("lat_data", data_out, 8'hA5);
    tick();
    check("lat_valid_drop", rd_valid, 0);
    check("lat_data_hold", data_out, 8'hA5);
    idle_cycles(3);
    check("lat_data_hold2", data_out, 8'hA5);

    // Back-to-back reads return on consecutive cycles in order
    do_write(5'd0, 8'h10);
    do_write(5'd1, 8'h11);
    do_write(5'd2, 8'h12);
    do_read(5'd0);
    do_read(5'd1);
    check("b2b_valid0", rd_valid, 1);
    do_read(5'd2);
    check("b2b_valid1", rd_valid, 1);
    drive_idle();
    tick();
    check("b2b_valid2", rd_valid, 1);
    check("b2b_last_data", data_out, 8'h12);
    tick();
    check("b2b_end", rd_valid, 0);
    idle_cycles(2);

    // Illegal strobe combination
    cs_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 5'd5; data_in = 8'hFF;
    tick();
    drive_idle();
    check("ill_err", err, 1);
    check("ill_err_flag", err_flag, 1);
    tick();
    check("ill_err_pulse", err, 0);
    check("ill_err_flag_sticky", err_flag, 1);
    check("ill_wr_count", wr_count, 32'(exp_wr));
    check("ill_rd_count", rd_count, 32'(exp_rd));
    do_read(5'd5);
    idle_cycles(4);
    check("ill_mem_untouched_q", sb_q.size(), 0);

    // Reset while a read is in flight
    do_write(5'd9, 8'h3C);
    do_read(5'd9);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_err_flag", err_flag, 0);
    drive_idle();
    repeat (2) tick();
    reset = 1'b0;

    // Access while busy is rejected
    cs_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 5'd7; data_in = 8'h55;
    tick();
    drive_idle();
    check("busy_err", err, 1);
    check("busy_err_flag", err_flag, 1);
    check("busy_wr_count", wr_count, 0);
    wait_idle(edges);
    check("reclear_rd_valid", rd_valid, 0);
    do_read(5'd9);
    do_read(5'd7);
    idle_cycles(4);

    // Write counter saturation
    for (int i = 0; i < 300; i++) do_write(5'(i), 8'(i * 7 + 1));
    drive_idle();
    tick();
    check("wr_sat", wr_count, 255);
    check("wr_sat_model", wr_count, 32'(exp_wr));
    do_read(5'd7);
    do_read(5'd31);
    do_read(5'd11);
    idle_cycles(4);
    check("rd_count_final", rd_count, 32'(exp_rd));
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
